// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller observation/control bundle
// Purpose: groups the ID/EX and IF/ID hazard inputs with the stall/flush
//   controls so the controller and pipeline connect through one port.
// Modports:
//   master - hazard controller: samples i* hazard fields, drives o* controls
//   slave  - pipeline side: drives i* hazard fields, samples o* controls
// Parameter CNT_W sets the width of the stall-cycle counter.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             iIDEXMemRead;
  logic [4:0]       iIDEXRegDest;
  logic [4:0]       iIFIDRs;
  logic [4:0]       iIFIDRt;
  logic             iIFIDUsesRt;
  logic             iRedirect;
  logic             iMultiStart;
  logic             iHold;
  logic             oPCEnable;
  logic             oIFIDEnable;
  logic             oIDEXEnable;
  logic             oIFIDFlush;
  logic             oIDEXBubble;
  logic             oMCDone;
  logic             oBusy;
  logic [CNT_W-1:0] oStallCycles;

  modport master (
    input  iIDEXMemRead, iIDEXRegDest, iIFIDRs, iIFIDRt, iIFIDUsesRt,
           iRedirect, iMultiStart, iHold,
    output oPCEnable, oIFIDEnable, oIDEXEnable, oIFIDFlush, oIDEXBubble,
           oMCDone, oBusy, oStallCycles
  );

  modport slave (
    output iIDEXMemRead, iIDEXRegDest, iIFIDRs, iIFIDRt, iIFIDUsesRt,
           iRedirect, iMultiStart, iHold,
    input  oPCEnable, oIFIDEnable, oIDEXEnable, oIFIDFlush, oIDEXBubble,
           oMCDone, oBusy, oStallCycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Purpose: drives PC, IF/ID and ID/EX enables plus IF/ID flush and ID/EX
//   bubble. Handles load-use stalls, EX redirects, external hold and
//   multi-cycle EX ops (RUN/MC_BUSY FSM with an 8-bit down-counter).
// Ports:
//   clock   - pipeline clock, rising edge
//   reset_n - asynchronous active-low reset
//   hzd     - pipe_hazard_ctrl_if.master (hazard inputs, control outputs)
// Parameters:
//   MC_LATENCY - total frozen cycles of a multi-cycle op (2..255)
//   CNT_W      - width of the saturating stall-cycle counter
module pipe_hazard_ctrl #(
  parameter int MC_LATENCY = 8,
  parameter int CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  pipe_hazard_ctrl_if.master  hzd
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  // Entry cycle counts as the first frozen cycle, so load one less.
  localparam logic [7:0] MC_LOAD = 8'(MC_LATENCY - 1);

  state_t           state;
  logic [7:0]       cnt;
  logic [CNT_W-1:0] stallCycles;

  logic loadUse;
  logic mcEntry;
  logic pcEn;
  logic ifidEn;
  logic idexEn;
  logic flush;
  logic bubble;
  logic mcDone;

  // $zero is never a real dependency, so a load to r0 never stalls.
  assign loadUse = hzd.iIDEXMemRead && (hzd.iIDEXRegDest != 5'd0) &&
                   ((hzd.iIDEXRegDest == hzd.iIFIDRs) ||
                    (hzd.iIFIDUsesRt && (hzd.iIDEXRegDest == hzd.iIFIDRt)));

  // Hold freezes ID/EX, so a pending mult/div simply enters after release.
  assign mcEntry = (state == RUN) && hzd.iMultiStart && !hzd.iHold;

  always_comb begin
    pcEn   = 1'b1;
    ifidEn = 1'b1;
    idexEn = 1'b1;
    flush  = 1'b0;
    bubble = 1'b0;
    mcDone = 1'b0;
    if (hzd.iHold) begin
      pcEn   = 1'b0;
      ifidEn = 1'b0;
      idexEn = 1'b0;
    end else if (mcEntry || (state == MC_BUSY && cnt != 8'd0)) begin
      pcEn   = 1'b0;
      ifidEn = 1'b0;
      idexEn = 1'b0;
    end else if (state == MC_BUSY) begin
      // cnt reached zero with no hold: release the front end this cycle.
      mcDone = 1'b1;
    end else if (hzd.iRedirect) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (loadUse) begin
      // Load leaves EX on the next edge, so a single bubble resolves it.
      pcEn   = 1'b0;
      ifidEn = 1'b0;
      bubble = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      cnt         <= 8'd0;
      stallCycles <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mcEntry) begin
            state <= MC_BUSY;
            cnt   <= MC_LOAD;
          end
        end
        MC_BUSY: begin
          // The op keeps executing under hold; only the release waits.
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (!hzd.iHold) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
      if (!pcEn && (stallCycles != {CNT_W{1'b1}})) begin
        stallCycles <= stallCycles + 1'b1;
      end
    end
  end

  assign hzd.oPCEnable    = pcEn;
  assign hzd.oIFIDEnable  = ifidEn;
  assign hzd.oIDEXEnable  = idexEn;
  assign hzd.oIFIDFlush   = flush;
  assign hzd.oIDEXBubble  = bubble;
  assign hzd.oMCDone      = mcDone;
  assign hzd.oBusy        = (state == MC_BUSY);
  assign hzd.oStallCycles = stallCycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int MC_LAT = 8;

  // Expected control vector: {pc, ifid, idex, flush, bubble, mcDone, busy}
  localparam logic [6:0] IDLE = 7'b1110000;
  localparam logic [6:0] LU   = 7'b0010100;
  localparam logic [6:0] SQ   = 7'b1111100;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] BSY  = 7'b0000001;
  localparam logic [6:0] DONE = 7'b1110011;

  logic clock;
  logic reset_n;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .MC_LATENCY(MC_LAT),
    .CNT_W     (CNT_W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .hzd    (bus.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  string            nameQ[$];
  logic [6:0]       vecQ[$];
  logic [CNT_W-1:0] stallQ[$];

  int compared   = 0;
  int mismatched = 0;
  int expStall   = 0;

  task automatic cyc(input string nm, input logic rst, input logic mr,
                     input logic [4:0] dst, input logic [4:0] rs,
                     input logic [4:0] rt, input logic ur, input logic rd,
                     input logic ms, input logic hd, input logic [6:0] ev);
    @(posedge clock);
    #1;
    reset_n          = rst;
    bus.iIDEXMemRead = mr;
    bus.iIDEXRegDest = dst;
    bus.iIFIDRs      = rs;
    bus.iIFIDRt      = rt;
    bus.iIFIDUsesRt  = ur;
    bus.iRedirect    = rd;
    bus.iMultiStart  = ms;
    bus.iHold        = hd;
    if (!rst) expStall = 0;
    nameQ.push_back(nm);
    vecQ.push_back(ev);
    stallQ.push_back(CNT_W'(expStall));
    if (!ev[6] && rst && expStall < (1 << CNT_W) - 1) expStall++;
  endtask

  // Monitor: the DUT presents a control word every cycle; check mid-cycle.
  always @(negedge clock) begin
    if (vecQ.size() > 0) begin
      string            nm;
      logic [6:0]       ev;
      logic [6:0]       av;
      logic [CNT_W-1:0] es;
      nm = nameQ.pop_front();
      ev = vecQ.pop_front();
      es = stallQ.pop_front();
      av = {bus.oPCEnable, bus.oIFIDEnable, bus.oIDEXEnable, bus.oIFIDFlush,
            bus.oIDEXBubble, bus.oMCDone, bus.oBusy};
      compared++;
      if (av !== ev || bus.oStallCycles !== es) begin
        mismatched++;
        $display("FAIL %s: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                 nm, av, bus.oStallCycles, ev, es);
      end
    end
  end

  initial begin
    reset_n          = 1'b0;
    bus.iIDEXMemRead = 1'b0;
    bus.iIDEXRegDest = 5'd0;
    bus.iIFIDRs      = 5'd0;
    bus.iIFIDRt      = 5'd0;
    bus.iIFIDUsesRt  = 1'b0;
    bus.iRedirect    = 1'b0;
    bus.iMultiStart  = 1'b0;
    bus.iHold        = 1'b0;

    //   name             rst mr dst    rs     rt     ur rd ms hd  expected
    cyc("reset",          0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);
    cyc("idle",           1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);
    cyc("lu_rs",          1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, LU);
    cyc("lu_rs_after",    1, 0, 5'd0, 5'd5, 5'd0, 0, 0, 0, 0, IDLE);
    cyc("dest0",          1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);
    cyc("rt_unused",      1, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0, 0, IDLE);
    cyc("lu_rt",          1, 1, 5'd5, 5'd3, 5'd5, 1, 0, 0, 0, LU);
    cyc("redir_and_lu",   1, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, SQ);
    cyc("redir",          1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, SQ);
    cyc("hold_lu",        1, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 1, FRZ);
    cyc("lu_after_hold",  1, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, LU);
    cyc("idle2",          1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);

    // First multi-cycle op: 8 frozen cycles, done on the 9th.
    cyc("mc1_entry",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, FRZ);
    for (int i = 0; i < MC_LAT - 1; i++)
      cyc($sformatf("mc1_busy%0d", i), 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, BSY);
    cyc("mc1_done_redir", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, DONE);
    cyc("mc1_after",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);

    // Second op: redirect ignored while busy, counter saturates, hold at cnt 0.
    cyc("mc2_entry_redir", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, FRZ);
    for (int i = 0; i < MC_LAT - 1; i++)
      cyc($sformatf("mc2_busy%0d", i), 1, 0, 5'd0, 5'd0, 5'd0, 0, (i == 2), 1, 0, BSY);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("mc2_hold%0d", i), 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, BSY);
    cyc("mc2_done",       1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, DONE);
    cyc("mc2_after",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);

    // Hold blocks MC entry; then reset aborts the op mid-busy.
    cyc("hold_blocks_mc", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, FRZ);
    cyc("mc3_entry",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, FRZ);
    cyc("mc3_busy",       1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, BSY);
    cyc("mc3_reset",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);
    cyc("post_reset0",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);
    cyc("post_reset1",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);
    cyc("post_reset_lu",  1, 1, 5'd9, 5'd0, 5'd9, 1, 0, 0, 0, LU);
    cyc("final_idle",     1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, IDLE);

    repeat (3) @(posedge clock);
    compared++;
    if (vecQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, expected 0", vecQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
